group4_sysid_check_ctrl: RTL and testbench
==========================================

# group4_sysid_check_ctrl

Boot-time sequencer for the system-ID slave. On a `start` pulse it acts as an Avalon-MM read master and fetches the system ID word (address 0). When compiled in, it also fetches the build timestamp word (address 1). It compares both against expected values and reports pass/fail with an error code. It sits between the reset/boot logic and the Qsys interconnect so that hardware/software mismatch is flagged before the CPU releases application code.

## Interface

Parameters:
- EXPECTED_ID, 0, 32-bit expected system ID (address 0).
- EXPECTED_TS, 1423087687, 32-bit expected timestamp (address 1).
- TIMEOUT_CYCLES, 255, maximum cycles `avm_read` may be held under `avm_waitrequest`; range 1..65535.
- MAX_RETRIES, 3, extra attempts after a timeout; range 0..15.

Ports:
- clock  in  1  single system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a check; sampled only in IDLE.
- avm_address  out  1  word address to the sysid slave.
- avm_read  out  1  read strobe.
- avm_readdata  in  32  read data; valid in the cycle `avm_read`=1 and `avm_waitrequest`=0.
- avm_waitrequest  in  1  fabric stall.
- busy  out  1  high from the cycle after `start` is accepted until `done`.
- done  out  1  one-cycle completion pulse.
- pass  out  1  result of the last check; held until the next `start`.
- error_code  out  2  0 = ok, 1 = ID mismatch, 2 = timestamp mismatch, 3 = timeout.
- id_value  out  32  last captured ID word.
- ts_value  out  32  last captured timestamp word.

## Operation

- FSM states:
  - IDLE: on `start`, go to RD_ID, clear `pass`/`error_code`, attempt counter = 0.
  - RD_ID: drive `avm_read`=1, `avm_address`=0. When `avm_waitrequest`=0, capture `id_value` and go to RD_TS, or to CHECK if the timestamp feature is off.
  - RD_TS: drive `avm_read`=1, `avm_address`=1. When `avm_waitrequest`=0, capture `ts_value` and go to CHECK.
  - CHECK: ID compare has priority over timestamp compare.
    - `id_value`≠EXPECTED_ID gives `error_code`=1.
    - Otherwise, `ts_value`≠EXPECTED_TS gives `error_code`=2.
    - Otherwise `pass`=1 and `error_code`=0.
    - Go to DONE.
  - DONE: `done`=1 for exactly one cycle, then IDLE.
  - BACKOFF: one cycle with `avm_read`=0, then RD_ID.
- Timeout counter:
  - Cleared on entry to each read state.
  - Increments each cycle `avm_waitrequest`=1.
  - When it reaches TIMEOUT_CYCLES, the read is abandoned: `avm_read` drops the next cycle.
  - If attempt counter < MAX_RETRIES: increment it and go to BACKOFF.
  - Otherwise: `error_code`=3, `pass`=0, go to DONE.
- `avm_address` and `avm_read` are stable while `avm_waitrequest`=1 (Avalon hold rule).
- `start` is ignored outside IDLE, including during DONE.
- A retry re-reads both words; `id_value` and `ts_value` keep their previous content until overwritten.

## Timing

- Reset values: `avm_read`=0, `avm_address`=0, `busy`=0, `done`=0, `pass`=0, `error_code`=0, `id_value`=0, `ts_value`=0, FSM=IDLE. Outputs clear asynchronously on `reset`.
- Reset mid-read drops `avm_read` immediately. No resume; a new `start` is needed.
- Zero-wait latency:
  - With the timestamp feature: `start` sampled at edge N, RD_ID at N+1, RD_TS at N+2, CHECK at N+3, `done` high at N+4.
  - Without the timestamp feature: `done` high at N+3.
- Each waitrequest cycle adds one cycle.
- `pass`/`error_code` are valid in the same cycle as `done` and hold afterward.
- A timeout is declared after exactly TIMEOUT_CYCLES stalled cycles in one read state.

## Configuration

- SYSID_CHECK_TS_EN defined:
  - RD_TS state is present; the timestamp is read and compared.
  - `error_code`=2 is reachable.
- SYSID_CHECK_TS_EN undefined:
  - RD_TS is removed; RD_ID goes directly to CHECK.
  - `ts_value` is tied to 0 and the timestamp compare is skipped.
  - `error_code`=2 is never produced.

## Test plan

- Zero wait, slave returns 0 then 1423087687, TS_EN on → `done` at start+4, `pass`=1, `error_code`=0, `ts_value`=1423087687.
- Slave returns ID 0x00000005 → `done` at start+4, `pass`=0, `error_code`=1, `id_value`=5.
- TS_EN on, timestamp read returns 1423087688 → `pass`=0, `error_code`=2; with TS_EN off, same stimulus → `pass`=1, `done` at start+3, `ts_value`=0.
- TIMEOUT_CYCLES=4, MAX_RETRIES=1, `avm_waitrequest` stuck high → two read attempts separated by one BACKOFF cycle, then `error_code`=3, `pass`=0, `done` pulse; `avm_read` never toggles during a stall.
- 3 waitrequest cycles on the first ID read, then released → `pass`=1, `done` at start+7, no retry.
- `reset` asserted while in RD_TS with waitrequest high → `avm_read`, `busy`, `pass`, `error_code` = 0 immediately; `start` during `busy` is ignored (no second `done`).

Source files
------------

// File: rtl/group4_sysid_check_ctrl.sv
// ---------------------------------------------------------------------------
// group4_sysid_check_ctrl
//
// Boot-time sequencer for the system-ID slave. A start pulse makes this block
// act as an Avalon-MM read master. It reads the system ID word (address 0)
// and, when SYSID_CHECK_TS_EN is defined, the build timestamp word (address 1).
// It compares the words against the expected values and reports pass/fail.
// A stalled read is abandoned after TIMEOUT_CYCLES waitrequest cycles. It is
// then retried up to MAX_RETRIES times; each retry restarts at the ID word.
//
// Build option:
//   SYSID_CHECK_TS_EN  defined   -> timestamp read/compare present
//                      undefined -> ID only, ts_value tied to 0
//
// Ports:
//   clock, reset        system clock, async active-high reset
//   start               request a check (sampled only while idle)
//   avm_address/read    Avalon-MM read master request
//   avm_readdata        read data, taken when read=1 and waitrequest=0
//   avm_waitrequest     fabric stall
//   busy                check in progress (includes the done cycle)
//   done                one-cycle completion pulse
//   pass, error_code    result (0 ok, 1 ID, 2 timestamp, 3 timeout), held
//   id_value, ts_value  last captured words
// ---------------------------------------------------------------------------
module group4_sysid_check_ctrl #(
   parameter logic [31:0] EXPECTED_ID    = 32'd0,
   parameter logic [31:0] EXPECTED_TS    = 32'd1423087687,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned MAX_RETRIES    = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic [31:0] avm_readdata,
   input  logic        avm_waitrequest,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [1:0]  error_code,
   output logic [31:0] id_value,
   output logic [31:0] ts_value
);

`ifdef SYSID_CHECK_TS_EN
   localparam logic TS_ON = 1'b1;
   typedef enum logic [2:0] {S_IDLE, S_RD_ID, S_RD_TS, S_CHECK, S_DONE, S_BACKOFF} state_t;
`else
   localparam logic TS_ON = 1'b0;
   typedef enum logic [2:0] {S_IDLE, S_RD_ID, S_CHECK, S_DONE, S_BACKOFF} state_t;
`endif

   // Counter value during the last allowed stalled cycle of a read.
   localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRIES);

   state_t      state, state_nx;
   logic [15:0] tmo_cnt, tmo_nx;
   logic [3:0]  att_cnt, att_nx;
   logic        pass_nx;
   logic [1:0]  err_nx;
   logic [31:0] id_nx;
   logic        abandon;
`ifdef SYSID_CHECK_TS_EN
   logic [31:0] ts_nx;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         tmo_cnt    <= '0;
         att_cnt    <= '0;
         pass       <= 1'b0;
         error_code <= 2'd0;
         id_value   <= '0;
      end else begin
         state      <= state_nx;
         tmo_cnt    <= tmo_nx;
         att_cnt    <= att_nx;
         pass       <= pass_nx;
         error_code <= err_nx;
         id_value   <= id_nx;
      end
   end

`ifdef SYSID_CHECK_TS_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) ts_value <= '0;
      else       ts_value <= ts_nx;
   end
`else
   assign ts_value = '0;
`endif

   always_comb begin
      state_nx    = state;
      tmo_nx      = tmo_cnt;
      att_nx      = att_cnt;
      pass_nx     = pass;
      err_nx      = error_code;
      id_nx       = id_value;
`ifdef SYSID_CHECK_TS_EN
      ts_nx       = ts_value;
`endif
      abandon     = 1'b0;
      avm_read    = 1'b0;
      avm_address = 1'b0;
      busy        = (state != S_IDLE);
      done        = 1'b0;

      case (state)
         S_IDLE: begin
            if (start) begin
               state_nx = S_RD_ID;
               pass_nx  = 1'b0;
               err_nx   = 2'd0;
               att_nx   = '0;
               tmo_nx   = '0;
            end
         end
         // Request lines come only from the state register, so they cannot
         // move while the fabric stalls.
         S_RD_ID: begin
            avm_read = 1'b1;
            if (!avm_waitrequest) begin
               id_nx    = avm_readdata;
               tmo_nx   = '0;
`ifdef SYSID_CHECK_TS_EN
               state_nx = S_RD_TS;
`else
               state_nx = S_CHECK;
`endif
            end else if (tmo_cnt == TMO_LAST) begin
               abandon = 1'b1;
            end else begin
               tmo_nx = tmo_cnt + 16'd1;
            end
         end
`ifdef SYSID_CHECK_TS_EN
         S_RD_TS: begin
            avm_read    = 1'b1;
            avm_address = 1'b1;
            if (!avm_waitrequest) begin
               ts_nx    = avm_readdata;
               state_nx = S_CHECK;
            end else if (tmo_cnt == TMO_LAST) begin
               abandon = 1'b1;
            end else begin
               tmo_nx = tmo_cnt + 16'd1;
            end
         end
`endif
         S_CHECK: begin
            state_nx = S_DONE;
            if (id_value != EXPECTED_ID)
               err_nx = 2'd1;
            else if (TS_ON && (ts_value != EXPECTED_TS))
               err_nx = 2'd2;
            else begin
               pass_nx = 1'b1;
               err_nx  = 2'd0;
            end
         end
         S_DONE: begin
            done     = 1'b1;
            state_nx = S_IDLE;
         end
         S_BACKOFF: begin
            tmo_nx   = '0;
            state_nx = S_RD_ID;
         end
         default: state_nx = S_IDLE;
      endcase

      // A stalled read ran out of time: retry from the ID word or give up.
      if (abandon) begin
         if (att_cnt < RETRY_MAX) begin
            att_nx   = att_cnt + 4'd1;
            state_nx = S_BACKOFF;
         end else begin
            pass_nx  = 1'b0;
            err_nx   = 2'd3;
            state_nx = S_DONE;
         end
      end
   end

endmodule

// File: tb/tb_group4_sysid_check_ctrl.sv
// ---------------------------------------------------------------------------
// Bench for group4_sysid_check_ctrl. For every check, a reference model builds
// the expected cycle-by-cycle trace. The model works from a stall plan (stalls
// per read, per attempt) and the words returned by the slave. One process
// walks the trace on falling edges. It compares the DUT outputs and then
// applies the stimulus for that cycle. Directed cases pin the model with
// literal latencies and results. Randomized cases follow.
// ---------------------------------------------------------------------------
module tb_group4_sysid_check_ctrl;

   localparam int          T   = 4;
   localparam int          R   = 1;
   localparam logic [31:0] EID = 32'd0;
   localparam logic [31:0] ETS = 32'd1423087687;
`ifdef SYSID_CHECK_TS_EN
   localparam bit TS = 1'b1;
`else
   localparam bit TS = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        avm_address, avm_read;
   logic [31:0] avm_readdata = '0;
   logic        avm_waitrequest = 1'b0;
   logic        busy, done, pass;
   logic [1:0]  error_code;
   logic [31:0] id_value, ts_value;

   group4_sysid_check_ctrl #(
      .EXPECTED_ID(EID), .EXPECTED_TS(ETS), .TIMEOUT_CYCLES(T), .MAX_RETRIES(R)
   ) dut (
      .clock(clock), .reset(reset), .start(start),
      .avm_address(avm_address), .avm_read(avm_read),
      .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
      .busy(busy), .done(done), .pass(pass), .error_code(error_code),
      .id_value(id_value), .ts_value(ts_value)
   );

   always #5 clock = ~clock;

   typedef struct {
      bit          st;
      bit          wr;
      logic [31:0] rdata;
      bit          rd;
      bit          addr;
      bit          bsy;
      bit          dn;
      bit          ps;
      logic [1:0]  err;
      logic [31:0] id;
      logic [31:0] ts;
   } cyc_t;

   cyc_t        tr[$];
   int          n_chk = 0;
   int          n_err = 0;
   int          lat;
   // Model state: result registers as visible to software.
   bit          m_pass = 0;
   logic [1:0]  m_err  = 0;
   logic [31:0] m_id   = 0;
   logic [31:0] m_ts   = 0;
   int          p_sid[16];
   int          p_sts[16];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic void push(bit st, bit wr, logic [31:0] d, bit rd, bit addr, bit bsy, bit dn);
      cyc_t c;
      c.st = st; c.wr = wr; c.rdata = d; c.rd = rd; c.addr = addr;
      c.bsy = bsy; c.dn = dn; c.ps = m_pass; c.err = m_err; c.id = m_id; c.ts = m_ts;
      tr.push_back(c);
   endfunction

   // One read: s stalled cycles then data, or T stalled cycles and a timeout.
   task automatic read_word(input bit addr, input logic [31:0] w, input int s, output bit to);
      int n;
      n  = (s >= T) ? T : s + 1;
      to = (s >= T);
      for (int k = 0; k < n; k++) begin
         bit stall;
         stall = (k < s);
         push(1'($urandom), stall, stall ? $urandom : w, 1'b1, addr, 1'b1, 1'b0);
      end
   endtask

   task automatic build(input logic [31:0] idw, input logic [31:0] tsw, input int gap);
      bit to;
      for (int g = 0; g < gap; g++) push(1'b0, 1'($urandom), $urandom, 0, 0, 0, 0);
      push(1'b1, 1'($urandom), $urandom, 0, 0, 0, 0);
      m_pass = 0; m_err = 0;
      for (int a = 0; a <= R; a++) begin
         read_word(1'b0, idw, p_sid[a], to);
         if (!to) m_id = idw;
         if (!to && TS) begin
            read_word(1'b1, tsw, p_sts[a], to);
            if (!to) m_ts = tsw;
         end
         if (to) begin
            if (a < R) begin
               push(1'($urandom), 1'($urandom), $urandom, 0, 0, 1, 0);
               continue;
            end
            m_pass = 0; m_err = 3;
            break;
         end
         push(1'($urandom), 1'($urandom), $urandom, 0, 0, 1, 0);
         if (m_id != EID)           m_err = 1;
         else if (TS && m_ts != ETS) m_err = 2;
         else begin m_pass = 1; m_err = 0; end
         break;
      end
      push(1'($urandom), 1'($urandom), $urandom, 0, 0, 1, 1);
      push(1'b0, 1'($urandom), $urandom, 0, 0, 0, 0);
   endtask

   // Compare-and-drive loop. lat is the trace index of the first done,
   // counted from the cycle in which start is driven.
   task automatic run_trace();
      int idx, st_idx;
      idx = 0; st_idx = -1; lat = -1;
      while (tr.size() > 0) begin
         cyc_t e;
         e = tr.pop_front();
         @(negedge clock);
         chk("avm_read",    32'(avm_read),    32'(e.rd));
         chk("avm_address", 32'(avm_address), 32'(e.addr));
         chk("busy",        32'(busy),        32'(e.bsy));
         chk("done",        32'(done),        32'(e.dn));
         chk("pass",        32'(pass),        32'(e.ps));
         chk("error_code",  32'(error_code),  32'(e.err));
         chk("id_value",    id_value,         e.id);
         chk("ts_value",    ts_value,         e.ts);
         if (e.st && st_idx < 0 && !e.bsy) st_idx = idx;
         if (done && lat < 0 && st_idx >= 0) lat = idx - st_idx;
         start           = e.st;
         avm_waitrequest = e.wr;
         avm_readdata    = e.rdata;
         idx++;
      end
   endtask

   task automatic one_check(input logic [31:0] idw, input logic [31:0] tsw, input int gap);
      build(idw, tsw, gap);
      run_trace();
   endtask

   function automatic void clear_plan();
      for (int i = 0; i < 16; i++) begin p_sid[i] = 0; p_sts[i] = 0; end
   endfunction

   initial begin
      // Reset values
      #1;
      chk("rst avm_read", 32'(avm_read), 0);
      chk("rst avm_address", 32'(avm_address), 0);
      chk("rst busy", 32'(busy), 0);
      chk("rst done", 32'(done), 0);
      chk("rst pass", 32'(pass), 0);
      chk("rst error_code", 32'(error_code), 0);
      chk("rst id_value", id_value, 0);
      chk("rst ts_value", ts_value, 0);
      @(negedge clock); @(negedge clock);
      reset = 1'b0;

      // Zero wait, matching words
      clear_plan();
      one_check(EID, ETS, 1);
      chk("lat ok", 32'(lat), TS ? 4 : 3);
      chk("pass ok", 32'(pass), 1);
      chk("err ok", 32'(error_code), 0);
      chk("ts ok", ts_value, TS ? ETS : 0);

      // ID mismatch
      one_check(32'd5, ETS, 1);
      chk("lat idbad", 32'(lat), TS ? 4 : 3);
      chk("pass idbad", 32'(pass), 0);
      chk("err idbad", 32'(error_code), 1);
      chk("id idbad", id_value, 5);

      // Timestamp mismatch (ignored without the timestamp read)
      one_check(EID, ETS + 32'd1, 1);
      chk("pass tsbad", 32'(pass), TS ? 0 : 1);
      chk("err tsbad", 32'(error_code), TS ? 2 : 0);
      chk("lat tsbad", 32'(lat), TS ? 4 : 3);
      chk("ts tsbad", ts_value, TS ? ETS + 32'd1 : 0);

      // Waitrequest stuck: T stalls, backoff, T stalls, timeout
      for (int i = 0; i < 16; i++) begin p_sid[i] = 99; p_sts[i] = 99; end
      one_check(EID, ETS, 1);
      chk("lat tmo", 32'(lat), 2 * T + 2);
      chk("pass tmo", 32'(pass), 0);
      chk("err tmo", 32'(error_code), 3);

      // Three stalls on the first ID read
      clear_plan();
      p_sid[0] = 3;
      one_check(EID, ETS, 1);
      chk("lat stall3", 32'(lat), TS ? 7 : 6);
      chk("pass stall3", 32'(pass), 1);

      // Reset in the middle of a stalled read
      clear_plan();
      @(negedge clock); start = 1; avm_waitrequest = 0; avm_readdata = EID;
      @(negedge clock); start = 0; avm_waitrequest = TS ? 1'b0 : 1'b1;
      @(negedge clock); avm_waitrequest = 1;
      chk("pre-rst avm_read", 32'(avm_read), 1);
      chk("pre-rst avm_address", 32'(avm_address), TS ? 1 : 0);
      chk("pre-rst busy", 32'(busy), 1);
      reset = 1'b1;
      #1;
      chk("midrst avm_read", 32'(avm_read), 0);
      chk("midrst busy", 32'(busy), 0);
      chk("midrst pass", 32'(pass), 0);
      chk("midrst error_code", 32'(error_code), 0);
      chk("midrst id_value", id_value, 0);
      @(negedge clock); @(negedge clock);
      chk("post-rst avm_read", 32'(avm_read), 0);
      reset = 1'b0; avm_waitrequest = 0;
      m_pass = 0; m_err = 0; m_id = 0; m_ts = 0;
      // No resume after reset: idle cycles with no start stay idle.
      for (int i = 0; i < 3; i++) push(1'b0, 1'($urandom), $urandom, 0, 0, 0, 0);
      run_trace();

      // Randomized checks
      for (int n = 0; n < 40; n++) begin
         logic [31:0] idw, tsw;
         for (int a = 0; a < 16; a++) begin
            int r;
            r = $urandom_range(0, 9);
            p_sid[a] = (r < 6) ? 0 : (r < 9) ? $urandom_range(1, T - 1) : $urandom_range(T, T + 2);
            r = $urandom_range(0, 9);
            p_sts[a] = (r < 6) ? 0 : (r < 9) ? $urandom_range(1, T - 1) : $urandom_range(T, T + 2);
         end
         idw = ($urandom_range(0, 3) == 0) ? $urandom : EID;
         tsw = ($urandom_range(0, 3) == 0) ? ETS ^ (32'd1 << $urandom_range(0, 31)) : ETS;
         one_check(idw, tsw, $urandom_range(0, 2));
         if (lat < 0) chk("done seen", 0, 1);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
